pca_seq_proj: RTL and testbench

Sequential, runtime-configurable PCA projector: accepts one D-feature sample over a ready/valid handshake and computes K principal-component scores y[k] = Σ_d (x[d] − mu[d])·W[k][d]. It uses a single time-multiplexed multiplier, with mean and weight coefficients loaded through a register-write port instead of being hard-coded. Scores are rounded, saturated and presented on a ready/valid output. It replaces the fixed-coefficient single-cycle projector in the PCA datapath when D, K or coefficients must change without resynthesis.

---
 rtl/pca_seq_proj_pkg.sv | 25 ++
 rtl/pca_seq_proj_if.sv | 37 +++
 rtl/pca_seq_proj_sat_round.sv | 34 +++
 rtl/pca_seq_proj.sv | 141 ++++++++++++++
 tb/tb_pca_seq_proj.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pca_seq_proj_pkg.sv
// Shared types and constants for the sequential PCA projector: FSM states,
// default-width accumulator/coefficient types, config select codes, index widths.
package pca_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ACC_W_DEF  = 40;
   localparam int COEF_W_DEF = 16;

   typedef logic signed [ACC_W_DEF-1:0]  acc_t;
   typedef logic signed [COEF_W_DEF-1:0] coef_t;

   localparam logic SEL_MU = 1'b0;
   localparam logic SEL_W  = 1'b1;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pca_seq_proj_if.sv
// Sample/score handshakes and the coefficient write port of the PCA projector.
// The projector is the slave; the sample source / score sink / config master is the master.
interface pca_seq_proj_if
   import pca_pkg::*;
#(
   parameter int D      = 4,
   parameter int K      = 2,
   parameter int IN_W   = 16,
   parameter int COEF_W = 16,
   parameter int OUT_W  = 16
);
   localparam int AW = idx_w(K * D);

   logic                  in_valid;
   logic                  in_ready;
   logic [D*IN_W-1:0]     x_flat;
   logic                  out_valid;
   logic                  out_ready;
   logic [K*OUT_W-1:0]    y_flat;
   logic [K-1:0]          y_sat;
   logic                  cfg_we;
   logic                  cfg_sel;
   logic [AW-1:0]         cfg_addr;
   logic [COEF_W-1:0]     cfg_data;
   logic                  cfg_err;

   modport master (
      output in_valid, x_flat, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
      input  in_ready, out_valid, y_flat, y_sat, cfg_err
   );

   modport slave (
      input  in_valid, x_flat, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
      output in_ready, out_valid, y_flat, y_sat, cfg_err
   );

endinterface

// File: rtl/pca_seq_proj_sat_round.sv
// Round-half-up by FRAC bits, then clamp the accumulator into a signed OUT_W score
// and flag whether clamping happened.
module pca_sat_round #(
   parameter int ACC_W = 40,
   parameter int OUT_W = 16,
   parameter int FRAC  = 12
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] value,
   output logic                    sat
);
   // One guard bit so adding the rounding half can never wrap.
   localparam logic signed [ACC_W:0] ONE   = (ACC_W+1)'(1);
   localparam logic signed [ACC_W:0] HALF  = ONE <<< (FRAC - 1);
   localparam logic signed [ACC_W:0] MAX_V = (ONE <<< (OUT_W - 1)) - ONE;
   localparam logic signed [ACC_W:0] MIN_V = -(ONE <<< (OUT_W - 1));

   logic signed [ACC_W:0] rounded;

   // NOTE: value and sat get a default before any branch, so no path infers a latch.
   always_comb begin
      rounded = ($signed({acc[ACC_W-1], acc}) + HALF) >>> FRAC;
      value   = rounded[OUT_W-1:0];
      sat     = 1'b0;
      if (rounded > MAX_V) begin
         value = MAX_V[OUT_W-1:0];
         sat   = 1'b1;
      end else if (rounded < MIN_V) begin
         value = MIN_V[OUT_W-1:0];
         sat   = 1'b1;
      end
   end

endmodule

// File: rtl/pca_seq_proj.sv
// Sequential PCA projector: one multiply-accumulate per cycle (k-major, d-minor)
// over runtime-loaded mean/weight registers, scores held on a ready/valid output.
module pca_seq_proj
   import pca_pkg::*;
#(
   parameter int D      = 4,
   parameter int K      = 2,
   parameter int IN_W   = 16,
   parameter int COEF_W = 16,
   parameter int OUT_W  = 16,
   parameter int FRAC   = 12,
   parameter int ACC_W  = 40
) (
   input  logic           clk,
   input  logic           rst,
   pca_seq_proj_if.slave  bus
);
   localparam int DW = idx_w(D);
   localparam int KW = idx_w(K);
   localparam int AW = idx_w(K * D);
   localparam int PW = IN_W + COEF_W + 1;

   state_t                   state_q;
   logic signed [IN_W-1:0]   x_q   [D];
   logic signed [COEF_W-1:0] mu_q  [D];
   logic signed [COEF_W-1:0] w_q   [K*D];
   logic signed [OUT_W-1:0]  y_q   [K];
   logic [K-1:0]             ysat_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [DW-1:0]            d_q;
   logic [KW-1:0]            k_q;
   logic                     cfg_err_q;

   // A write arriving with an accepted sample is parked until that sample finishes.
   logic                     pend_q;
   logic                     pend_sel_q;
   logic [AW-1:0]            pend_addr_q;
   logic [COEF_W-1:0]        pend_data_q;

   logic                     accept, last_d, last_k, cfg_ok, pend_fire, wr_en, wr_sel;
   logic [AW-1:0]            wr_addr, w_idx;
   logic [COEF_W-1:0]        wr_data;
   logic signed [IN_W:0]     centered;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [OUT_W-1:0]  y_rnd;
   logic                     y_rnd_sat;

   assign bus.in_ready  = !rst && (state_q == IDLE || (state_q == DONE && bus.out_ready));
   assign bus.out_valid = (state_q == DONE);
   assign bus.y_sat     = ysat_q;
   assign bus.cfg_err   = cfg_err_q;

   always_comb begin
      bus.y_flat = '0;
      for (int i = 0; i < K; i++) bus.y_flat[i*OUT_W +: OUT_W] = y_q[i];
   end

   assign accept = bus.in_valid && bus.in_ready;
   assign last_d = (d_q == DW'(D - 1));
   assign last_k = (k_q == KW'(K - 1));
   assign cfg_ok = (state_q == IDLE) &&
                   ((bus.cfg_sel == SEL_MU) ? (int'(bus.cfg_addr) < D)
                                            : (int'(bus.cfg_addr) < K * D));

   assign pend_fire = pend_q && (state_q == MAC) && last_d && last_k;
   assign wr_en     = pend_fire || (bus.cfg_we && cfg_ok && !accept);
   assign wr_sel    = pend_fire ? pend_sel_q  : bus.cfg_sel;
   assign wr_addr   = pend_fire ? pend_addr_q : bus.cfg_addr;
   assign wr_data   = pend_fire ? pend_data_q : bus.cfg_data;

   assign w_idx    = AW'(int'(k_q) * D + int'(d_q));
   assign centered = (IN_W+1)'(x_q[d_q]) - (IN_W+1)'(mu_q[d_q]);
   assign prod     = PW'(centered) * PW'(w_q[w_idx]);
   assign acc_sum  = acc_q + ACC_W'(prod);

   pca_sat_round #(.ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC(FRAC)) u_sat_round (
      .acc   (acc_sum),
      .value (y_rnd),
      .sat   (y_rnd_sat)
   );

   // NOTE: <= everywhere here, so each register sees pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         d_q       <= '0;
         k_q       <= '0;
         ysat_q    <= '0;
         cfg_err_q <= 1'b0;
         pend_q    <= 1'b0;
         for (int i = 0; i < D; i++)     mu_q[i] <= '0;
         for (int i = 0; i < K * D; i++) w_q[i]  <= '0;
         for (int i = 0; i < K; i++)     y_q[i]  <= '0;
      end else begin
         if (bus.cfg_we && !cfg_ok) cfg_err_q <= 1'b1;
         if (bus.cfg_we && cfg_ok && accept) pend_q <= 1'b1;
         else if (pend_fire)                 pend_q <= 1'b0;

         if (wr_en) begin
            if (wr_sel == SEL_MU) mu_q[wr_addr[DW-1:0]] <= wr_data;
            else                  w_q[wr_addr]          <= wr_data;
         end

         if (accept) begin
            state_q <= MAC;
            acc_q   <= '0;
            d_q     <= '0;
            k_q     <= '0;
         end else if (state_q == MAC) begin
            if (last_d) begin
               y_q[k_q]    <= y_rnd;
               ysat_q[k_q] <= y_rnd_sat;
               acc_q       <= '0;
               d_q         <= '0;
               k_q         <= k_q + 1'b1;
               if (last_k) state_q <= DONE;
            end else begin
               acc_q <= acc_sum;
               d_q   <= d_q + 1'b1;
            end
         end else if (state_q == DONE && bus.out_ready) begin
            state_q <= IDLE;
         end
      end
   end

   // NOTE: sample and parked-write payload carry no reset; each is written before it is read.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < D; i++) x_q[i] <= bus.x_flat[i*IN_W +: IN_W];
      end
      if (bus.cfg_we && cfg_ok && accept) begin
         pend_sel_q  <= bus.cfg_sel;
         pend_addr_q <= bus.cfg_addr;
         pend_data_q <= bus.cfg_data;
      end
   end

endmodule

// File: tb/tb_pca_seq_proj.sv
// Randomized and directed bench for pca_seq_proj against a plain-arithmetic
// projection model (integer sums, floor division, clamp).
module tb_pca_seq_proj;
   import pca_pkg::*;

   localparam int D = 4, K = 2, IN_W = 16, COEF_W = 16, OUT_W = 16, FRAC = 12, ACC_W = 40;
   localparam int AW = idx_w(K * D);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pca_seq_proj_if #(.D(D), .K(K), .IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

   pca_seq_proj #(.D(D), .K(K), .IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W),
                  .FRAC(FRAC), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int     n_checks = 0;
   int     n_fail   = 0;
   int     mu_m [D];
   int     w_m  [K*D];
   longint exp_y [K];
   longint exp_s [K];

   task automatic check(input string tag, input longint got, input longint want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   function automatic logic [D*IN_W-1:0] pack_x(input int a0, input int a1, input int a2, input int a3);
      return {IN_W'(a3), IN_W'(a2), IN_W'(a1), IN_W'(a0)};
   endfunction

   function automatic int srnd(input int mag);
      return int'($urandom_range(0, 2 * mag)) - mag;
   endfunction

   // y[k] = floor((sum_d (x[d]-mu[d])*W[k][d] + 2^(FRAC-1)) / 2^FRAC), then clamped.
   function automatic void model_eval(input logic [D*IN_W-1:0] xf);
      longint scale = longint'(1) << FRAC;
      longint hi = (longint'(1) << (OUT_W - 1)) - 1;
      longint lo = -(longint'(1) << (OUT_W - 1));
      for (int k = 0; k < K; k++) begin
         longint acc = 0;
         longint num, q;
         for (int d = 0; d < D; d++) begin
            longint xv = $signed(xf[d*IN_W +: IN_W]);
            acc += (xv - mu_m[d]) * w_m[k*D + d];
         end
         num = acc + scale / 2;
         q   = num / scale;
         if (num < 0 && q * scale != num) q -= 1;
         exp_s[k] = (q > hi || q < lo) ? 1 : 0;
         exp_y[k] = (q > hi) ? hi : (q < lo) ? lo : q;
      end
   endfunction

   task automatic cfg_write(input logic sel, input int addr, input int data, input bit legal);
      bus.cfg_we   = 1'b1;
      bus.cfg_sel  = sel;
      bus.cfg_addr = AW'(addr);
      bus.cfg_data = COEF_W'(data);
      @(posedge clk);
      @(negedge clk);
      bus.cfg_we = 1'b0;
      if (legal) begin
         if (sel == SEL_MU) mu_m[addr] = data;
         else               w_m[addr]  = data;
      end
   endtask

   task automatic issue(input logic [D*IN_W-1:0] xf);
      model_eval(xf);
      bus.x_flat   = xf;
      bus.in_valid = 1'b1;
      #1;
      check("in_ready_at_accept", bus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      for (int k = 0; k < K; k++) begin
         check($sformatf("%s_y%0d", tag, k), longint'($signed(bus.y_flat[k*OUT_W +: OUT_W])), exp_y[k]);
         check($sformatf("%s_sat%0d", tag, k), longint'(bus.y_sat[k]), exp_s[k]);
      end
   endtask

   // n0 = clock edges already elapsed since the accepting edge.
   task automatic wait_done(input int n0, input string tag);
      int n = n0;
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, D * K);
      check_outputs(tag);
   endtask

   task automatic hold_out(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         #1;
         check({tag, "_hold_valid"}, bus.out_valid, 1);
         check({tag, "_hold_in_ready"}, bus.in_ready, 0);
         check_outputs({tag, "_hold"});
         @(negedge clk);
      end
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("idle_after_release", bus.out_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mu_init [D]   = '{23934, 12524, 15393, 4912};
      int w_init  [K*D] = '{1480, -346, 3509, 1468, 2689, 2991, -710, -309};
      int rnd_w   [4]   = '{2048, 2047, -2048, -2049};
      int rnd_y   [4]   = '{1, 0, 0, -1};
      int spur;
      logic [D*IN_W-1:0] xa, xb;

      for (int i = 0; i < D; i++) mu_m[i] = 0;
      for (int i = 0; i < K * D; i++) w_m[i] = 0;
      bus.in_valid = 1'b0; bus.x_flat = '0; bus.out_ready = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;

      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_y_flat", bus.y_flat, 0);
      check("post_rst_y_sat", bus.y_sat, 0);
      check("post_rst_cfg_err", bus.cfg_err, 0);

      // Test-plan coefficients; x = mu must project to zero.
      for (int d = 0; d < D; d++) cfg_write(SEL_MU, d, mu_init[d], 1);
      for (int i = 0; i < K * D; i++) cfg_write(SEL_W, i, w_init[i], 1);
      check("legal_writes_cfg_err", bus.cfg_err, 0);
      issue(pack_x(mu_init[0], mu_init[1], mu_init[2], mu_init[3]));
      wait_done(0, "x_eq_mu");
      check("x_eq_mu_flat", bus.y_flat, 0);
      release_out();

      // Unit step on feature 0, stall the consumer, then back-to-back handoff.
      issue(pack_x(mu_init[0] + 4096, mu_init[1], mu_init[2], mu_init[3]));
      wait_done(0, "step");
      check("step_y0_const", $signed(bus.y_flat[0 +: OUT_W]), 1480);
      check("step_y1_const", $signed(bus.y_flat[OUT_W +: OUT_W]), 2689);
      xb = pack_x(mu_init[0], mu_init[1] + 4096, mu_init[2] - 4096, mu_init[3]);
      bus.x_flat = xb;
      bus.in_valid = 1'b1;
      hold_out(5, "stall");
      bus.out_ready = 1'b1;
      issue(xb);
      bus.out_ready = 1'b0;
      wait_done(0, "b2b");
      release_out();

      // Saturation both ways.
      for (int d = 0; d < D; d++) cfg_write(SEL_MU, d, 0, 1);
      for (int d = 0; d < D; d++) cfg_write(SEL_W, d, 32767, 1);
      issue(pack_x(32767, 32767, 32767, 32767));
      wait_done(0, "sat_pos");
      check("sat_pos_y0_const", $signed(bus.y_flat[0 +: OUT_W]), 32767);
      check("sat_pos_flag0_const", bus.y_sat[0], 1);
      release_out();
      issue(pack_x(-32768, -32768, -32768, -32768));
      wait_done(0, "sat_neg");
      check("sat_neg_y0_const", $signed(bus.y_flat[0 +: OUT_W]), -32768);
      check("sat_neg_flag0_const", bus.y_sat[0], 1);
      release_out();

      // Rounding at the half-LSB boundary.
      for (int d = 1; d < D; d++) cfg_write(SEL_W, d, 0, 1);
      for (int i = 0; i < 4; i++) begin
         cfg_write(SEL_W, 0, rnd_w[i], 1);
         issue(pack_x(1, 0, 0, 0));
         wait_done(0, $sformatf("round%0d", i));
         check($sformatf("round%0d_const", i), $signed(bus.y_flat[0 +: OUT_W]), rnd_y[i]);
         release_out();
      end

      // Write in the same cycle as an accept: this sample sees the old weight.
      xa = pack_x(4096, 0, 0, 0);
      bus.cfg_we = 1'b1; bus.cfg_sel = SEL_W; bus.cfg_addr = AW'(0); bus.cfg_data = COEF_W'(100);
      issue(xa);
      bus.cfg_we = 1'b0;
      w_m[0] = 100;
      wait_done(0, "same_cycle_old");
      release_out();
      issue(xa);
      wait_done(0, "same_cycle_new");
      release_out();
      check("same_cycle_cfg_err", bus.cfg_err, 0);

      // Dropped writes: busy, then mean address out of range.
      issue(xa);
      bus.cfg_we = 1'b1; bus.cfg_sel = SEL_MU; bus.cfg_addr = AW'(0); bus.cfg_data = COEF_W'(777);
      @(posedge clk);
      @(negedge clk);
      bus.cfg_we = 1'b0;
      check("busy_write_cfg_err", bus.cfg_err, 1);
      wait_done(1, "busy_write");
      release_out();
      cfg_write(SEL_MU, D, 555, 0);
      check("range_write_cfg_err", bus.cfg_err, 1);
      issue(xa);
      wait_done(0, "range_write");
      release_out();

      // Randomized coefficients, samples, stalls and handoffs.
      for (int it = 0; it < 12; it++) begin
         int mag = (it % 3 == 0) ? 32767 : 2048;
         for (int j = 0; j < 3; j++) begin
            logic sel = 1'($urandom_range(0, 1));
            int   addr = (sel == SEL_W) ? int'($urandom_range(0, K * D - 1)) : int'($urandom_range(0, D - 1));
            cfg_write(sel, addr, srnd(mag), 1);
         end
         mag = (it % 3 == 0) ? 32767 : 4000;
         issue(pack_x(srnd(mag), srnd(mag), srnd(mag), srnd(mag)));
         wait_done(0, $sformatf("rnd%0d", it));
         hold_out(int'($urandom_range(0, 2)), $sformatf("rnd%0d", it));
         if ($urandom_range(0, 1) == 1) begin
            bus.out_ready = 1'b1;
            issue(pack_x(srnd(mag), srnd(mag), srnd(mag), srnd(mag)));
            bus.out_ready = 1'b0;
            wait_done(0, $sformatf("rnd%0d_b2b", it));
         end
         release_out();
      end
      check("cfg_err_sticky", bus.cfg_err, 1);

      // Reset in the middle of a sample.
      issue(pack_x(srnd(4000), srnd(4000), srnd(4000), srnd(4000)));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", bus.in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < D; i++) mu_m[i] = 0;
      for (int i = 0; i < K * D; i++) w_m[i] = 0;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_y_flat", bus.y_flat, 0);
      check("mid_rst_y_sat", bus.y_sat, 0);
      check("mid_rst_cfg_err", bus.cfg_err, 0);
      spur = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid) spur++;
      end
      check("no_spurious_output", spur, 0);
      issue(pack_x(srnd(32767), srnd(32767), srnd(32767), srnd(32767)));
      wait_done(0, "zero_coeffs");
      check("zero_coeffs_flat", bus.y_flat, 0);
      release_out();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
